cart_ascii_mapper: RTL and testbench

- Multi-slot, multi-mode ASCII-family MSX cartridge mapper; successor to the single-mode ASCII16 mapper.
- Holds independent bank-register files for SLOTS cartridge slots.
- Each slot runs ASCII8, ASCII16 or ASCII16 R-type with battery-SRAM overlay, selected at runtime.
- Sits between the slot decoder and the SDRAM/SRAM arbiter. It produces mem_addr, sram_oe and sram_we for the currently selected slot.

---
 rtl/cart_ascii_pkg.sv | 32 +++
 rtl/cart_ascii_mapper_regs.sv | 60 ++++++
 rtl/cart_ascii_mapper.sv | 85 ++++++++
 tb/tb_cart_ascii_mapper.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_ascii_pkg.sv
// Shared types, register-window constants and reset-default helpers for the
// ASCII-family cartridge mapper.
package cart_ascii_pkg;

    typedef enum logic [1:0] {
        ASCII8  = 2'd0,
        ASCII16 = 2'd1,
        RTYPE   = 2'd2,
        RSVD    = 2'd3
    } mode_t;

    typedef logic [3:0][7:0] banks_t;

    // addr[15:13] of the 6000-7FFF bank-register window
    localparam logic [2:0] BANK_WIN  = 3'b011;
    localparam logic [3:0] RTYPE_WIN = 4'h7;
    localparam logic [1:0] SRAM_WIN  = 2'b10;
    localparam logic [7:0] RTYPE_B0  = 8'h0F;

    function automatic banks_t mode_defaults(mode_t m);
        banks_t b;
        b = '0;
        if (m == RTYPE) b[0] = RTYPE_B0;
        return b;
    endfunction

    // R-type folds the upper ROM half so that d[4] selects a 16-bank page.
    function automatic logic [7:0] rtype_value(logic [7:0] d);
        return d[4] ? {5'b00010, d[2:0]} : {3'b000, d[4:0]};
    endfunction

endpackage

// File: rtl/cart_ascii_mapper_regs.sv
// One slot's bank-register file with its registered mode copy; a mode change
// reloads the defaults of the new mode and overrides any concurrent write.
module ascii_bank_regs
    import cart_ascii_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode_i,
    input  logic         wr_en_i,
    input  logic [15:11] addr_i,
    input  logic [7:0]   data_i,
    output logic [1:0]   mode_o,
    output logic [31:0]  banks_o
);

    mode_t  mode_in;
    mode_t  mode_q, mode_d;
    banks_t banks_q, banks_d;

    assign mode_in = mode_t'(mode_i);

    // NOTE: every variable gets its hold value first so no branch infers a latch.
    always_comb begin
        mode_d  = mode_q;
        banks_d = banks_q;
        if (mode_in != mode_q) begin
            mode_d  = mode_in;
            banks_d = mode_defaults(mode_in);
        end else if (wr_en_i) begin
            case (mode_q)
                ASCII8: begin
                    if (addr_i[15:13] == BANK_WIN) banks_d[addr_i[12:11]] = data_i;
                end
                RTYPE: begin
                    if (addr_i[15:12] == RTYPE_WIN) banks_d[1] = rtype_value(data_i);
                end
                default: begin
                    if (addr_i[15:13] == BANK_WIN && !addr_i[11])
                        banks_d[{1'b0, addr_i[12]}] = data_i;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= mode_in;
            banks_q <= mode_defaults(mode_in);
        end else begin
            mode_q  <= mode_d;
            banks_q <= banks_d;
        end
    end

    // While reset is held the decode already sees the values being loaded.
    assign mode_o  = reset ? mode_i : 2'(mode_q);
    assign banks_o = reset ? mode_defaults(mode_in) : banks_q;

endmodule

// File: rtl/cart_ascii_mapper.sv
// Multi-slot ASCII8/ASCII16/R-type MSX mapper: per-slot register files, slot
// muxing and ROM/SRAM address decode for the active slot.
module cart_ascii_mapper
    import cart_ascii_pkg::*;
#(
    parameter int         SLOTS    = 2,
    parameter int         SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    parameter int         SRAM_AW  = 13,
    parameter logic [7:0] SRAM_MIN = 8'h10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [24:0]          rom_size,
    input  logic [2*SLOTS-1:0]   mode,
    input  logic [15:0]          addr,
    input  logic [7:0]           d_from_cpu,
    input  logic                 wr,
    input  logic                 cs,
    input  logic [SLOT_W-1:0]    slot,
    output logic [24:0]          mem_addr,
    output logic                 sram_oe,
    output logic                 sram_we
);

    logic [SLOTS-1:0][1:0]  slot_mode;
    logic [SLOTS-1:0][31:0] slot_banks;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        localparam logic [SLOT_W-1:0] IDX = SLOT_W'(s);
        ascii_bank_regs u_regs (
            .clk     (clk),
            .reset   (reset),
            .mode_i  (mode[2*s +: 2]),
            .wr_en_i (cs & wr & (slot == IDX)),
            .addr_i  (addr[15:11]),
            .data_i  (d_from_cpu),
            .mode_o  (slot_mode[s]),
            .banks_o (slot_banks[s])
        );
    end

    mode_t  cur_mode;
    banks_t cur_banks;

    // An out-of-range slot index reads slot 0; its writes reach no slot.
    always_comb begin
        cur_mode  = mode_t'(slot_mode[0]);
        cur_banks = slot_banks[0];
        for (int s = 1; s < SLOTS; s++) begin
            if (slot == SLOT_W'(s)) begin
                cur_mode  = mode_t'(slot_mode[s]);
                cur_banks = slot_banks[s];
            end
        end
    end

    logic [7:0] field8, field16, mask8, mask16, smask, bank;
    logic [1:0] idx;
    logic       is8, sel, we_reg_ok;
    logic       unused_rom_bits;

    assign field8  = rom_size[20:13];
    assign field16 = rom_size[21:14];
    assign mask8   = field8 - 8'd1;
    assign mask16  = field16 - 8'd1;
    assign smask   = (field8 > SRAM_MIN) ? field8 : SRAM_MIN;
    assign unused_rom_bits = ^{rom_size[24:22], rom_size[12:0]};

    assign is8       = (cur_mode == ASCII8);
    assign idx       = is8 ? {addr[15], addr[13]} : {1'b0, addr[15]};
    assign bank      = cur_banks[idx];
    assign sel       = |(bank & smask);
    assign we_reg_ok = is8 ? idx[1] : (idx == 2'd1);

    assign sram_oe = cs & sel;
    assign sram_we = cs & wr & sel & (addr[15:14] == SRAM_WIN) & we_reg_ok;

    always_comb begin
        mem_addr = '0;
        if (sram_oe)  mem_addr[SRAM_AW-1:0] = addr[SRAM_AW-1:0];
        else if (is8) mem_addr[20:0]        = {bank & mask8, addr[12:0]};
        else          mem_addr[21:0]        = {bank & mask16, addr[13:0]};
    end

endmodule

// File: tb/tb_cart_ascii_mapper.sv
// Self-checking bench: directed scenarios then random traffic, compared every
// cycle against an arithmetic model of the mapper's register and decode rules.
module tb_cart_ascii_mapper;

    localparam int SLOTS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] rom_size;
    logic [3:0]  mode;
    logic [15:0] addr;
    logic [7:0]  d_from_cpu;
    logic        wr, cs;
    logic [0:0]  slot;
    logic [24:0] mem_addr;
    logic        sram_oe, sram_we;

    always #5 clk = ~clk;

    cart_ascii_mapper #(.SLOTS(SLOTS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_size   (rom_size),
        .mode       (mode),
        .addr       (addr),
        .d_from_cpu (d_from_cpu),
        .wr         (wr),
        .cs         (cs),
        .slot       (slot),
        .mem_addr   (mem_addr),
        .sram_oe    (sram_oe),
        .sram_we    (sram_we)
    );

    int total = 0;
    int bad   = 0;
    int m_mode [SLOTS];
    int m_bank [SLOTS][4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int defval(int md, int i);
        return (md == 2 && i == 0) ? 'h0F : 0;
    endfunction

    function automatic int mode_of(int s);
        return int'(mode[2*s +: 2]);
    endfunction

    task automatic model_load_defaults(int s, int md);
        m_mode[s] = md;
        for (int i = 0; i < 4; i++) m_bank[s][i] = defval(md, i);
    endtask

    // Register update seen at a clock edge, from the inputs present at that edge.
    task automatic model_edge();
        int a, v;
        a = int'(addr);
        v = int'(d_from_cpu);
        for (int s = 0; s < SLOTS; s++) begin
            if (reset || mode_of(s) != m_mode[s]) begin
                model_load_defaults(s, mode_of(s));
            end else if (cs && wr && int'(slot) == s) begin
                if (m_mode[s] == 0) begin
                    if (a >= 'h6000 && a < 'h8000) m_bank[s][(a - 'h6000) / 'h800] = v;
                end else if (m_mode[s] == 2) begin
                    if (a >= 'h7000 && a < 'h8000)
                        m_bank[s][1] = ((v / 16) % 2 == 1) ? 16 + v % 8 : v % 32;
                end else begin
                    if (a >= 'h6000 && a < 'h6800) m_bank[s][0] = v;
                    else if (a >= 'h7000 && a < 'h7800) m_bank[s][1] = v;
                end
            end
        end
    endtask

    task automatic expected(output int ea, output int eoe, output int ewe);
        int md, a, rsz, f8, f16, mask8, mask16, smask, idx, bank, s;
        int b[4];
        s   = int'(slot);
        a   = int'(addr);
        rsz = int'(rom_size);
        if (reset) begin
            md = mode_of(s);
            for (int i = 0; i < 4; i++) b[i] = defval(md, i);
        end else begin
            md = m_mode[s];
            for (int i = 0; i < 4; i++) b[i] = m_bank[s][i];
        end
        f8     = (rsz / 8192) % 256;
        f16    = (rsz / 16384) % 256;
        mask8  = (f8 + 255) % 256;
        mask16 = (f16 + 255) % 256;
        smask  = (f8 > 16) ? f8 : 16;
        idx    = (md == 0) ? (a / 32768) * 2 + (a / 8192) % 2 : a / 32768;
        bank   = b[idx];
        eoe    = (cs && (bank & smask) != 0) ? 1 : 0;
        ewe    = (eoe == 1 && wr && a >= 'h8000 && a < 'hC000 &&
                  ((md == 0) ? idx >= 2 : idx == 1)) ? 1 : 0;
        if (eoe == 1)     ea = a % 8192;
        else if (md == 0) ea = (bank & mask8) * 8192 + a % 8192;
        else              ea = (bank & mask16) * 16384 + a % 16384;
    endtask

    // Inputs are driven at the falling edge; outputs compared 1 ns later.
    task automatic cyc(input string tag);
        int ea, eoe, ewe;
        #1;
        expected(ea, eoe, ewe);
        check({tag, ".mem_addr"}, 32'(mem_addr), ea);
        check({tag, ".sram_oe"},  32'(sram_oe),  eoe);
        check({tag, ".sram_we"},  32'(sram_we),  ewe);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input int s);
        cs = c; wr = w; addr = a; d_from_cpu = d; slot = 1'(s);
    endtask

    initial begin
        reset = 1'b1; rom_size = 25'h40000; mode = 4'b0000;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 0);
        for (int s = 0; s < SLOTS; s++) model_load_defaults(s, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h4000, 8'h00, 0);
        cyc("rst0");
        cyc("rst1");
        reset = 1'b0;

        // ASCII8 bank write and read-back through the 6000h window
        drive(1'b1, 1'b1, 16'h6800, 8'h05, 0); cyc("t1_wr");
        drive(1'b1, 1'b0, 16'h6000, 8'h00, 0); #1;
        check("t1_addr", 32'(mem_addr), 32'h00A000);
        cyc("t1_rd");

        // ASCII8 SRAM overlay: 10h misses smask=20h, 20h hits it
        drive(1'b1, 1'b1, 16'h7800, 8'h10, 0); cyc("t2_wr10");
        drive(1'b1, 1'b1, 16'hAB00, 8'h5A, 0); cyc("t2_rd10");
        drive(1'b1, 1'b1, 16'h7800, 8'h20, 0); cyc("t2_wr20");
        drive(1'b1, 1'b1, 16'hAB00, 8'h5A, 0); #1;
        check("t2_we", 32'(sram_we), 32'd1);
        check("t2_saddr", 32'(mem_addr), 32'h000B00);
        cyc("t2_sram");
        drive(1'b1, 1'b1, 16'h4000, 8'h5A, 0); #1;
        check("t2_we_rom", 32'(sram_we), 32'd0);
        cyc("t2_rom");
        drive(1'b0, 1'b1, 16'hAB00, 8'h5A, 0); #1;
        check("t2_cs0_oe", 32'(sram_oe), 32'd0);
        cyc("t2_cs0");

        // ASCII16, 128K ROM, ignored 6800h window
        mode = 4'b0001; rom_size = 25'h20000;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 0); cyc("t3_mode");
        drive(1'b1, 1'b1, 16'h7000, 8'h09, 0); cyc("t3_wr");
        drive(1'b1, 1'b0, 16'h8123, 8'h00, 0); #1;
        check("t3_addr", 32'(mem_addr), 32'h004123);
        cyc("t3_rd");
        drive(1'b1, 1'b1, 16'h6800, 8'h03, 0); cyc("t3_ign");
        drive(1'b1, 1'b0, 16'h8123, 8'h00, 0); #1;
        check("t3_addr2", 32'(mem_addr), 32'h004123);
        cyc("t3_rd2");

        // R-type defaults and the d[4] fold
        mode = 4'b0010; rom_size = 25'h80000;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 0); cyc("t4_mode");
        drive(1'b1, 1'b0, 16'h4000, 8'h00, 0); #1;
        check("t4_b0", 32'(mem_addr), 32'h03C000);
        cyc("t4_rd0");
        drive(1'b1, 1'b1, 16'h7000, 8'h17, 0); cyc("t4_wr17");
        drive(1'b1, 1'b0, 16'h8000, 8'h00, 0); #1;
        check("t4_b1_17", 32'(mem_addr), 32'h05C000);
        cyc("t4_rd17");
        drive(1'b1, 1'b1, 16'h7000, 8'h05, 0); cyc("t4_wr05");
        drive(1'b1, 1'b0, 16'h8000, 8'h00, 0); #1;
        check("t4_b1_05", 32'(mem_addr), 32'h014000);
        cyc("t4_rd05");

        // Two slots in different modes, toggled every cycle
        mode = 4'b0100; rom_size = 25'h40000;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 0); cyc("t5_mode");
        drive(1'b1, 1'b1, 16'h6000, 8'h03, 0); cyc("t5_wr0");
        drive(1'b1, 1'b1, 16'h6000, 8'h02, 1); cyc("t5_wr1");
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 16'h4000, 8'h00, i % 2); #1;
            check("t5_toggle", 32'(mem_addr), (i % 2 == 1) ? 32'h008000 : 32'h006000);
            cyc("t5_rd");
        end

        // Mode change wins over a same-cycle write; reset restores defaults
        mode = 4'b1000;
        drive(1'b1, 1'b1, 16'h6000, 8'h55, 1); cyc("t6_race");
        drive(1'b1, 1'b0, 16'h4000, 8'h00, 1); #1;
        check("t6_b0", 32'(mem_addr), 32'h03C000);
        cyc("t6_rd");
        drive(1'b1, 1'b1, 16'h7000, 8'h03, 1); cyc("t6_wr");
        reset = 1'b1;
        drive(1'b1, 1'b1, 16'h6000, 8'h07, 0); cyc("t6_rst");
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h4000, 8'h00, 0); #1;
        check("t6_s0_def", 32'(mem_addr), 32'h000000);
        cyc("t6_rd0");
        drive(1'b1, 1'b0, 16'h8000, 8'h00, 1); #1;
        check("t6_s1_def", 32'(mem_addr), 32'h000000);
        cyc("t6_rd1");

        // Random traffic across modes, slots, ROM sizes and resets
        for (int n = 0; n < 600; n++) begin
            logic [15:0] base;
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 9) == 0) rom_size = 25'(1) << $urandom_range(10, 24);
            case ($urandom_range(0, 7))
                0: base = 16'h4000;
                1: base = 16'h6000;
                2: base = 16'h6800;
                3: base = 16'h7000;
                4: base = 16'h7800;
                5: base = 16'h8000;
                6: base = 16'hA000;
                default: base = 16'($urandom);
            endcase
            drive($urandom_range(0, 4) != 0, 1'($urandom), base + 16'($urandom_range(0, 'h7FF)),
                  8'($urandom), $urandom_range(0, 1));
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
